fabric_boot_sequencer: RTL and testbench
========================================

Name: fabric_boot_sequencer

Overview:
- Parametrised boot and reconfiguration sequencer between N bitstream sources and fabric_config.
- Source 0 is the self-initiated SPI controller; sources 1..NUM_SOURCES-1 are passive receivers.
- Selects and forwards one source, issues startup and warmboot start pulses to the controller, counts words, and detects timeout, short, overrun and bad-slot errors.
- Holds the fabric in reset until the configuration completes.

Parameters:
DATA_WIDTH, 32, bitstream word width
NUM_SOURCES, 2, number of bitstream sources (>=1); source 0 = controller
SLOT_WIDTH, 4, width of slot fields
NUM_SLOTS, 16, valid slots are 0..NUM_SLOTS-1
DEFAULT_SLOT, 0, slot used for the startup boot
BITSTREAM_LENGTH_WORDS, 32'h1762, words per complete bitstream
TIMEOUT_CYCLES, 32'h100000, maximum idle cycles allowed in START/LOAD/FLUSH
SEL_WIDTH, $clog2(NUM_SOURCES) (min 1), width of the source select

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
src_sel_i  in  SEL_WIDTH  selected source
src_data_i  in  NUM_SOURCES*DATA_WIDTH  packed source words; source k at [k*DATA_WIDTH +: DATA_WIDTH]
src_valid_i  in  NUM_SOURCES  per-source word valid
ctrl_start_o  out  1  one-cycle start pulse to the SPI controller
ctrl_slot_o  out  SLOT_WIDTH  slot accompanying ctrl_start_o
ctrl_busy_i  in  1  SPI controller busy
warmboot_boot_i  in  1  fabric warmboot request (level)
warmboot_slot_i  in  SLOT_WIDTH  requested slot
bitstream_data_o  out  DATA_WIDTH  word to fabric_config
bitstream_valid_o  out  1  word valid to fabric_config
config_busy_i  in  1  fabric_config busy
configured_i  in  1  fabric_config configured
fabric_reset_o  out  1  fabric user-logic reset
boot_active_o  out  1  high in START, LOAD or FLUSH
word_count_o  out  32  words forwarded in the current load
error_o  out  1  sticky error flag
error_code_o  out  2  0 TIMEOUT, 1 SHORT, 2 BADSLOT, 3 OVERRUN

Behaviour:
- Reset state:
  - State IDLE; startup_pending=1.
  - fabric_reset_o=1; every other output 0.
  - Word and timeout counters cleared.
- Source select:
  - src_sel_i is latched into sel_q on every accepted start: IDLE exit, DONE/ERROR restart.
  - Changes to src_sel_i during START/LOAD/FLUSH are ignored.
  - src_sel_i >= NUM_SOURCES behaves as source 0.
- Forwarding:
  - Registered, 1-cycle latency: bitstream_data_o/valid_o <= src_data/src_valid of sel_q.
  - Active only in START and LOAD, and on the passive first word that triggers LOAD.
  - Otherwise bitstream_valid_o=0; incoming words are dropped.
- State IDLE:
  - startup_pending && src_sel_i==0: ctrl_start_o=1 with ctrl_slot_o=DEFAULT_SLOT for exactly one cycle; clear pending; go to START.
  - src_sel_i!=0: clear pending; on the first src_valid_i of that source, forward the word, count=1, go to LOAD.
- State START:
  - ctrl_busy_i=1 -> LOAD.
  - A valid word arriving here is forwarded and counted.
  - TIMEOUT_CYCLES without busy -> ERROR(TIMEOUT).
- State LOAD:
  - Each forwarded word increments word_count_o and reloads the timeout counter.
  - count reaches BITSTREAM_LENGTH_WORDS -> FLUSH.
  - sel_q==0 and ctrl_busy_i falls with count < length -> ERROR(SHORT).
  - TIMEOUT_CYCLES without a word -> ERROR(TIMEOUT).
- State FLUSH:
  - configured_i=1 && config_busy_i=0 -> DONE.
  - A valid word on sel_q -> ERROR(OVERRUN); the word is not forwarded.
  - TIMEOUT_CYCLES expire -> ERROR(TIMEOUT).
- State DONE:
  - fabric_reset_o=0.
  - Warmboot is accepted when warmboot_boot_i && src_sel_i==0 && !ctrl_busy_i && !config_busy_i:
    - slot < NUM_SLOTS: one-cycle ctrl_start_o with ctrl_slot_o=warmboot_slot_i; clear count and error_o; fabric_reset_o=1 in the same cycle; go to START.
    - slot >= NUM_SLOTS: no start; ERROR(BADSLOT).
  - src_sel_i!=0 and a valid word arrives: forward it; count=1; fabric_reset_o=1; clear error_o; go to LOAD.
  - Level warmboot is re-evaluated only in DONE/ERROR, so one request yields one start.
- State ERROR:
  - error_o=1 with code held; fabric_reset_o=1.
  - Recovery uses the same accept rules as DONE.
- Counters and timeout:
  - Word count is 32-bit, cleared on every start.
  - Timeout counter is reloaded on every state entry and on every forwarded word.
- Reset mid-operation: returns to IDLE with startup_pending=1, so a fresh startup boot follows.

Test Plan:
1. Bench: BITSTREAM_LENGTH_WORDS=4, TIMEOUT_CYCLES=16, sel=0. Release reset; ctrl_busy_i rises 2 cycles after start; feed 4 words A0..A3; then configured_i=1 -> exactly one ctrl_start_o with slot 0; bitstream_valid_o pulses 1 cycle after each word; word_count_o=4; DONE; fabric_reset_o falls; error_o=0.
2. From DONE, warmboot_boot_i held 10 cycles with slot 5 -> exactly one ctrl_start_o with ctrl_slot_o=5; fabric_reset_o=1 in the same cycle; count cleared. Repeat with slot 16 on NUM_SLOTS=16 -> no start; error_o=1; code 2.
3. sel=1 with NUM_SOURCES=3: source 1 streams 4 words while source 2 toggles garbage -> only source-1 data forwarded; no ctrl_start_o ever; DONE after configured_i.
4. ctrl_busy_i falls after 2 of 4 words -> ERROR, code 1. No words for 16 cycles in LOAD -> ERROR, code 0. 5th word in FLUSH -> code 3; word not forwarded.
5. rst_i asserted mid-LOAD at count=2 -> next cycle: IDLE; all outputs at reset values; a new startup ctrl_start_o with slot 0 after release.
6. src_sel_i toggled 0->1 during LOAD -> ignored; load completes from source 0.

Source files
------------

// File: rtl/fabric_boot_sequencer.sv
// Boot/reconfiguration sequencer: picks one bitstream source, kicks the SPI controller,
// forwards words to fabric_config and holds the fabric in reset until configuration completes.
module fabric_boot_sequencer #(
  parameter int          DATA_WIDTH             = 32,
  parameter int          NUM_SOURCES            = 2,
  parameter int          SLOT_WIDTH             = 4,
  parameter int          NUM_SLOTS              = 16,
  parameter int          DEFAULT_SLOT           = 0,
  parameter logic [31:0] BITSTREAM_LENGTH_WORDS = 32'h1762,
  parameter logic [31:0] TIMEOUT_CYCLES         = 32'h100000,
  parameter int          SEL_WIDTH              = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [SEL_WIDTH-1:0]              src_sel_i,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data_i,
  input  logic [NUM_SOURCES-1:0]            src_valid_i,
  output logic                              ctrl_start_o,
  output logic [SLOT_WIDTH-1:0]             ctrl_slot_o,
  input  logic                              ctrl_busy_i,
  input  logic                              warmboot_boot_i,
  input  logic [SLOT_WIDTH-1:0]             warmboot_slot_i,
  output logic [DATA_WIDTH-1:0]             bitstream_data_o,
  output logic                              bitstream_valid_o,
  input  logic                              config_busy_i,
  input  logic                              configured_i,
  output logic                              fabric_reset_o,
  output logic                              boot_active_o,
  output logic [31:0]                       word_count_o,
  output logic                              error_o,
  output logic [1:0]                        error_code_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_LOAD, S_FLUSH, S_DONE, S_ERROR} state_e;

  localparam logic [1:0] E_TIMEOUT = 2'd0;
  localparam logic [1:0] E_SHORT   = 2'd1;
  localparam logic [1:0] E_BADSLOT = 2'd2;
  localparam logic [1:0] E_OVERRUN = 2'd3;

  state_e                  state_q;
  logic                    startup_pending_q;
  logic [SEL_WIDTH-1:0]    sel_q;
  logic [31:0]             tmo_q;
  logic [31:0]             word_count_q;
  logic                    ctrl_start_q;
  logic [SLOT_WIDTH-1:0]   ctrl_slot_q;
  logic [DATA_WIDTH-1:0]   bs_data_q;
  logic                    bs_valid_q;
  logic                    fabric_reset_q;
  logic                    boot_active_q;
  logic                    error_q;
  logic [1:0]              error_code_q;

  logic [DATA_WIDTH-1:0]   src_word [NUM_SOURCES];
  logic [SEL_WIDTH-1:0]    req_sel;
  logic [SEL_WIDTH-1:0]    in_sel;
  logic                    in_valid;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    req_passive;
  logic                    wb_req;
  logic                    wb_slot_ok;
  logic                    tmo_hit;
  logic [31:0]             cnt_inc;
  logic [31:0]             cnt_next;

  for (genvar k = 0; k < NUM_SOURCES; k++) begin : g_unpack
    assign src_word[k] = src_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Out-of-range selects fold onto the controller; the live select is only honoured
  // where a new load can begin, otherwise the latched one steers the mux.
  assign req_sel     = (32'(src_sel_i) >= 32'(NUM_SOURCES)) ? '0 : src_sel_i;
  assign in_sel      = (state_q inside {S_IDLE, S_DONE, S_ERROR}) ? req_sel : sel_q;
  assign in_valid    = src_valid_i[in_sel];
  assign in_data     = src_word[in_sel];
  assign req_passive = (req_sel != '0) && in_valid;
  assign wb_req      = warmboot_boot_i && (req_sel == '0) && !ctrl_busy_i && !config_busy_i;
  assign wb_slot_ok  = 32'(warmboot_slot_i) < 32'(NUM_SLOTS);
  assign tmo_hit     = tmo_q >= (TIMEOUT_CYCLES - 32'd1);
  assign cnt_inc     = word_count_q + 32'd1;
  assign cnt_next    = in_valid ? cnt_inc : word_count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= S_IDLE;
      startup_pending_q <= 1'b1;
      sel_q             <= '0;
      tmo_q             <= '0;
      word_count_q      <= '0;
      ctrl_start_q      <= 1'b0;
      ctrl_slot_q       <= '0;
      bs_data_q         <= '0;
      bs_valid_q        <= 1'b0;
      fabric_reset_q    <= 1'b1;
      boot_active_q     <= 1'b0;
      error_q           <= 1'b0;
      error_code_q      <= '0;
    end else begin
      ctrl_start_q <= 1'b0;
      bs_valid_q   <= 1'b0;
      tmo_q        <= tmo_q + 32'd1;
      case (state_q)
        S_IDLE: begin
          if (startup_pending_q && (req_sel == '0)) begin
            startup_pending_q <= 1'b0;
            ctrl_start_q      <= 1'b1;
            ctrl_slot_q       <= SLOT_WIDTH'(DEFAULT_SLOT);
            sel_q             <= '0;
            word_count_q      <= '0;
            tmo_q             <= '0;
            boot_active_q     <= 1'b1;
            state_q           <= S_START;
          end else if (req_sel != '0) begin
            startup_pending_q <= 1'b0;
            if (in_valid) begin
              bs_data_q     <= in_data;
              bs_valid_q    <= 1'b1;
              word_count_q  <= 32'd1;
              sel_q         <= req_sel;
              tmo_q         <= '0;
              boot_active_q <= 1'b1;
              state_q       <= S_LOAD;
            end
          end
        end
        S_START: begin
          if (in_valid) begin
            bs_data_q    <= in_data;
            bs_valid_q   <= 1'b1;
            word_count_q <= cnt_inc;
          end
          if (ctrl_busy_i) begin
            tmo_q   <= '0;
            state_q <= S_LOAD;
          end else if (in_valid) begin
            tmo_q <= '0;
          end else if (tmo_hit) begin
            error_q        <= 1'b1;
            error_code_q   <= E_TIMEOUT;
            fabric_reset_q <= 1'b1;
            boot_active_q  <= 1'b0;
            tmo_q          <= '0;
            state_q        <= S_ERROR;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            bs_data_q    <= in_data;
            bs_valid_q   <= 1'b1;
            word_count_q <= cnt_inc;
            tmo_q        <= '0;
          end
          // A word landing on the same cycle the controller drops busy still counts.
          if (cnt_next >= BITSTREAM_LENGTH_WORDS) begin
            tmo_q   <= '0;
            state_q <= S_FLUSH;
          end else if ((sel_q == '0) && !ctrl_busy_i) begin
            error_q        <= 1'b1;
            error_code_q   <= E_SHORT;
            fabric_reset_q <= 1'b1;
            boot_active_q  <= 1'b0;
            tmo_q          <= '0;
            state_q        <= S_ERROR;
          end else if (!in_valid && tmo_hit) begin
            error_q        <= 1'b1;
            error_code_q   <= E_TIMEOUT;
            fabric_reset_q <= 1'b1;
            boot_active_q  <= 1'b0;
            tmo_q          <= '0;
            state_q        <= S_ERROR;
          end
        end
        S_FLUSH: begin
          if (in_valid || tmo_hit) begin
            error_q        <= 1'b1;
            error_code_q   <= in_valid ? E_OVERRUN : E_TIMEOUT;
            fabric_reset_q <= 1'b1;
            boot_active_q  <= 1'b0;
            tmo_q          <= '0;
            state_q        <= S_ERROR;
          end else if (configured_i && !config_busy_i) begin
            fabric_reset_q <= 1'b0;
            boot_active_q  <= 1'b0;
            tmo_q          <= '0;
            state_q        <= S_DONE;
          end
        end
        S_DONE, S_ERROR: begin
          if (wb_req && wb_slot_ok) begin
            ctrl_start_q   <= 1'b1;
            ctrl_slot_q    <= warmboot_slot_i;
            word_count_q   <= '0;
            error_q        <= 1'b0;
            fabric_reset_q <= 1'b1;
            sel_q          <= '0;
            tmo_q          <= '0;
            boot_active_q  <= 1'b1;
            state_q        <= S_START;
          end else if (wb_req) begin
            error_q        <= 1'b1;
            error_code_q   <= E_BADSLOT;
            fabric_reset_q <= 1'b1;
            tmo_q          <= '0;
            state_q        <= S_ERROR;
          end else if (req_passive) begin
            bs_data_q      <= in_data;
            bs_valid_q     <= 1'b1;
            word_count_q   <= 32'd1;
            error_q        <= 1'b0;
            fabric_reset_q <= 1'b1;
            sel_q          <= req_sel;
            tmo_q          <= '0;
            boot_active_q  <= 1'b1;
            state_q        <= S_LOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ctrl_start_o      = ctrl_start_q;
  assign ctrl_slot_o       = ctrl_slot_q;
  assign bitstream_data_o  = bs_data_q;
  assign bitstream_valid_o = bs_valid_q;
  assign fabric_reset_o    = fabric_reset_q;
  assign boot_active_o     = boot_active_q;
  assign word_count_o      = word_count_q;
  assign error_o           = error_q;
  assign error_code_o      = error_code_q;

endmodule

// File: tb/tb_fabric_boot_sequencer.sv
// Scoreboard bench for fabric_boot_sequencer: 3 sources, 4-word bitstreams, 16-cycle timeout.
module tb_fabric_boot_sequencer;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int SW = 5;
  localparam int SELW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i;
  logic [SELW-1:0]   src_sel_i;
  logic [NS*DW-1:0]  src_data_i;
  logic [NS-1:0]     src_valid_i;
  logic              ctrl_start_o;
  logic [SW-1:0]     ctrl_slot_o;
  logic              ctrl_busy_i;
  logic              warmboot_boot_i;
  logic [SW-1:0]     warmboot_slot_i;
  logic [DW-1:0]     bitstream_data_o;
  logic              bitstream_valid_o;
  logic              config_busy_i;
  logic              configured_i;
  logic              fabric_reset_o;
  logic              boot_active_o;
  logic [31:0]       word_count_o;
  logic              error_o;
  logic [1:0]        error_code_o;

  int checks = 0;
  int passed = 0;
  int start_cnt = 0;
  logic [DW-1:0] exp_q[$];

  fabric_boot_sequencer #(
    .DATA_WIDTH(DW), .NUM_SOURCES(NS), .SLOT_WIDTH(SW), .NUM_SLOTS(16), .DEFAULT_SLOT(0),
    .BITSTREAM_LENGTH_WORDS(32'd4), .TIMEOUT_CYCLES(32'd16)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .src_sel_i(src_sel_i), .src_data_i(src_data_i),
    .src_valid_i(src_valid_i), .ctrl_start_o(ctrl_start_o), .ctrl_slot_o(ctrl_slot_o),
    .ctrl_busy_i(ctrl_busy_i), .warmboot_boot_i(warmboot_boot_i), .warmboot_slot_i(warmboot_slot_i),
    .bitstream_data_o(bitstream_data_o), .bitstream_valid_o(bitstream_valid_o),
    .config_busy_i(config_busy_i), .configured_i(configured_i), .fabric_reset_o(fabric_reset_o),
    .boot_active_o(boot_active_o), .word_count_o(word_count_o), .error_o(error_o),
    .error_code_o(error_code_o)
  );

  // Output monitor: counts start pulse cycles and pops the scoreboard on every forwarded word.
  always @(posedge clk) begin
    #2;
    if (ctrl_start_o === 1'b1) start_cnt++;
    if (bitstream_valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL fwd_unexpected: got word %h, expected no word", bitstream_data_o);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (bitstream_data_o !== e) $display("FAIL fwd_data: got %h expected %h", bitstream_data_o, e);
        else passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int src, input logic [DW-1:0] d, input bit fwd);
    src_valid_i[src] = 1'b1;
    src_data_i[src*DW +: DW] = d;
    if (fwd) exp_q.push_back(d);
  endtask

  task automatic send(input int src, input logic [DW-1:0] d, input bit fwd);
    set_word(src, d, fwd);
    tick();
    src_valid_i[src] = 1'b0;
  endtask

  task automatic warm_to_load(input logic [SW-1:0] slot);
    src_sel_i = '0;
    warmboot_slot_i = slot;
    warmboot_boot_i = 1'b1;
    tick();
    warmboot_boot_i = 1'b0;
    ctrl_busy_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; src_sel_i = '0; src_data_i = '0; src_valid_i = '0; ctrl_busy_i = 1'b0;
    warmboot_boot_i = 1'b0; warmboot_slot_i = '0; config_busy_i = 1'b0; configured_i = 1'b0;
    repeat (3) tick();
    checks++; if (fabric_reset_o !== 1'b1) $display("FAIL rst_fabric_reset: got %b expected 1", fabric_reset_o); else passed++;
    checks++; if ({ctrl_start_o, bitstream_valid_o, boot_active_o, error_o, error_code_o} !== 6'd0)
      $display("FAIL rst_flags: got %b expected 000000", {ctrl_start_o, bitstream_valid_o, boot_active_o, error_o, error_code_o}); else passed++;
    checks++; if (word_count_o !== 32'd0 || bitstream_data_o !== '0 || ctrl_slot_o !== '0)
      $display("FAIL rst_values: got count %0d data %h slot %0d expected 0", word_count_o, bitstream_data_o, ctrl_slot_o); else passed++;
    checks++; if (start_cnt !== 0) $display("FAIL rst_no_start: got %0d starts expected 0", start_cnt); else passed++;
  endtask

  task automatic test_startup_boot();
    rst_i = 1'b0;
    tick();
    checks++; if (ctrl_start_o !== 1'b1 || ctrl_slot_o !== 5'd0 || boot_active_o !== 1'b1)
      $display("FAIL startup_pulse: got start %b slot %0d active %b expected 1 0 1", ctrl_start_o, ctrl_slot_o, boot_active_o); else passed++;
    tick();
    checks++; if (ctrl_start_o !== 1'b0) $display("FAIL startup_one_cycle: got %b expected 0", ctrl_start_o); else passed++;
    ctrl_busy_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      send(0, 32'hA0 + i, 1'b1);
      if (i == 0) begin
        checks++; if (bitstream_valid_o !== 1'b1) $display("FAIL fwd_latency: got valid %b expected 1", bitstream_valid_o); else passed++;
      end
    end
    checks++; if (word_count_o !== 32'd4 || boot_active_o !== 1'b1)
      $display("FAIL startup_count: got %0d active %b expected 4 1", word_count_o, boot_active_o); else passed++;
    ctrl_busy_i = 1'b0; configured_i = 1'b1;
    tick();
    configured_i = 1'b0;
    checks++; if (fabric_reset_o !== 1'b0 || error_o !== 1'b0 || boot_active_o !== 1'b0)
      $display("FAIL startup_done: got rst %b err %b active %b expected 0 0 0", fabric_reset_o, error_o, boot_active_o); else passed++;
    checks++; if (start_cnt !== 1) $display("FAIL startup_start_count: got %0d expected 1", start_cnt); else passed++;
  endtask

  task automatic test_warmboot();
    int s0;
    s0 = start_cnt;
    warmboot_slot_i = 5'd5; warmboot_boot_i = 1'b1;
    tick();
    checks++; if (ctrl_start_o !== 1'b1 || ctrl_slot_o !== 5'd5 || fabric_reset_o !== 1'b1 || word_count_o !== 32'd0)
      $display("FAIL wb_start: got start %b slot %0d rst %b count %0d expected 1 5 1 0", ctrl_start_o, ctrl_slot_o, fabric_reset_o, word_count_o); else passed++;
    repeat (9) tick();
    warmboot_boot_i = 1'b0;
    checks++; if (start_cnt !== s0 + 1) $display("FAIL wb_single_start: got %0d expected %0d", start_cnt, s0 + 1); else passed++;
    ctrl_busy_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send(0, 32'hB0 + i, 1'b1);
    ctrl_busy_i = 1'b0; configured_i = 1'b1;
    tick();
    configured_i = 1'b0;
    checks++; if (fabric_reset_o !== 1'b0 || word_count_o !== 32'd4 || error_o !== 1'b0)
      $display("FAIL wb_done: got rst %b count %0d err %b expected 0 4 0", fabric_reset_o, word_count_o, error_o); else passed++;
    s0 = start_cnt;
    warmboot_slot_i = 5'd16; warmboot_boot_i = 1'b1;
    tick();
    warmboot_boot_i = 1'b0;
    checks++; if (error_o !== 1'b1 || error_code_o !== 2'd2 || fabric_reset_o !== 1'b1 || ctrl_start_o !== 1'b0)
      $display("FAIL wb_badslot: got err %b code %0d rst %b start %b expected 1 2 1 0", error_o, error_code_o, fabric_reset_o, ctrl_start_o); else passed++;
    tick();
    checks++; if (start_cnt !== s0) $display("FAIL wb_badslot_nostart: got %0d expected %0d", start_cnt, s0); else passed++;
  endtask

  task automatic test_passive_source();
    int s0;
    s0 = start_cnt;
    src_sel_i = 2'd1;
    for (int i = 0; i < 4; i++) begin
      src_valid_i[2] = 1'($urandom_range(0, 1)); src_data_i[2*DW +: DW] = $urandom;
      src_valid_i[0] = 1'($urandom_range(0, 1)); src_data_i[0 +: DW] = $urandom;
      send(1, 32'hC0 + i, 1'b1);
      src_valid_i[2] = 1'b0; src_valid_i[0] = 1'b0;
      if (i == 0) begin
        checks++; if (error_o !== 1'b0 || boot_active_o !== 1'b1)
          $display("FAIL passive_enter: got err %b active %b expected 0 1", error_o, boot_active_o); else passed++;
      end
    end
    checks++; if (word_count_o !== 32'd4) $display("FAIL passive_count: got %0d expected 4", word_count_o); else passed++;
    send(2, 32'hBAD0BAD0, 1'b0);
    checks++; if (error_o !== 1'b0 || boot_active_o !== 1'b1)
      $display("FAIL passive_other_src_flush: got err %b active %b expected 0 1", error_o, boot_active_o); else passed++;
    configured_i = 1'b1;
    tick();
    configured_i = 1'b0;
    checks++; if (fabric_reset_o !== 1'b0 || error_o !== 1'b0)
      $display("FAIL passive_done: got rst %b err %b expected 0 0", fabric_reset_o, error_o); else passed++;
    checks++; if (start_cnt !== s0) $display("FAIL passive_no_start: got %0d expected %0d", start_cnt, s0); else passed++;
    src_sel_i = '0;
  endtask

  task automatic test_errors();
    warm_to_load(5'd3);
    for (int i = 0; i < 2; i++) send(0, 32'hD0 + i, 1'b1);
    ctrl_busy_i = 1'b0;
    tick();
    checks++; if (error_o !== 1'b1 || error_code_o !== 2'd1 || word_count_o !== 32'd2 || boot_active_o !== 1'b0)
      $display("FAIL err_short: got err %b code %0d count %0d active %b expected 1 1 2 0", error_o, error_code_o, word_count_o, boot_active_o); else passed++;
    warm_to_load(5'd3);
    send(0, 32'hE0, 1'b1);
    repeat (15) tick();
    checks++; if (error_o !== 1'b0 || boot_active_o !== 1'b1)
      $display("FAIL err_timeout_early: got err %b active %b expected 0 1", error_o, boot_active_o); else passed++;
    tick();
    checks++; if (error_o !== 1'b1 || error_code_o !== 2'd0 || fabric_reset_o !== 1'b1)
      $display("FAIL err_timeout: got err %b code %0d rst %b expected 1 0 1", error_o, error_code_o, fabric_reset_o); else passed++;
    ctrl_busy_i = 1'b0;
    warm_to_load(5'd4);
    for (int i = 0; i < 4; i++) send(0, 32'hF0 + i, 1'b1);
    ctrl_busy_i = 1'b0;
    send(0, 32'hDEADBEEF, 1'b0);
    checks++; if (bitstream_valid_o !== 1'b0 || error_o !== 1'b1 || error_code_o !== 2'd3)
      $display("FAIL err_overrun: got valid %b err %b code %0d expected 0 1 3", bitstream_valid_o, error_o, error_code_o); else passed++;
  endtask

  task automatic test_reset_mid_load();
    int s0;
    warm_to_load(5'd2);
    for (int i = 0; i < 2; i++) send(0, 32'h100 + i, 1'b1);
    checks++; if (word_count_o !== 32'd2) $display("FAIL midrst_pre_count: got %0d expected 2", word_count_o); else passed++;
    rst_i = 1'b1; ctrl_busy_i = 1'b0;
    tick();
    checks++; if (fabric_reset_o !== 1'b1 || {ctrl_start_o, bitstream_valid_o, boot_active_o, error_o, error_code_o} !== 6'd0 || word_count_o !== 32'd0)
      $display("FAIL midrst_values: got rst %b flags %b count %0d expected 1 000000 0", fabric_reset_o,
               {ctrl_start_o, bitstream_valid_o, boot_active_o, error_o, error_code_o}, word_count_o); else passed++;
    s0 = start_cnt;
    rst_i = 1'b0;
    tick();
    checks++; if (ctrl_start_o !== 1'b1 || ctrl_slot_o !== 5'd0)
      $display("FAIL midrst_restart: got start %b slot %0d expected 1 0", ctrl_start_o, ctrl_slot_o); else passed++;
    tick();
    checks++; if (start_cnt !== s0 + 1) $display("FAIL midrst_start_count: got %0d expected %0d", start_cnt, s0 + 1); else passed++;
  endtask

  task automatic test_sel_ignored();
    ctrl_busy_i = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) send(0, 32'h200 + i, 1'b1);
    src_sel_i = 2'd1;
    for (int i = 2; i < 4; i++) begin
      set_word(1, 32'h5A5A0000 + i, 1'b0);
      send(0, 32'h200 + i, 1'b1);
      src_valid_i[1] = 1'b0;
    end
    checks++; if (word_count_o !== 32'd4 || error_o !== 1'b0)
      $display("FAIL sel_ignored_count: got %0d err %b expected 4 0", word_count_o, error_o); else passed++;
    ctrl_busy_i = 1'b0; configured_i = 1'b1;
    tick();
    configured_i = 1'b0;
    checks++; if (fabric_reset_o !== 1'b0 || error_o !== 1'b0 || boot_active_o !== 1'b0)
      $display("FAIL sel_ignored_done: got rst %b err %b active %b expected 0 0 0", fabric_reset_o, error_o, boot_active_o); else passed++;
    src_sel_i = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_startup_boot();
    test_warmboot();
    test_passive_source();
    test_errors();
    test_reset_mid_load();
    test_sel_ignored();
    checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending words expected 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
